ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_bitstream_loader.sv | 177 +++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words onto the ccff chain head and optionally recirculates the chain to CRC-check it (CCFF_BITSTREAM_LOADER_VERIFY_EN).
// Start-to-done is CHAIN_LEN+2 cycles (+CHAIN_LEN with verify) plus one per source stall; s_ready drops while the word register is still busy.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W  = $clog2(N_WORDS + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
    localparam logic [1:0] VERIFY = 2'd2;
`endif
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WORDS    = WCNT_W'(N_WORDS);

    logic [1:0]        state;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  bit_idx;
    logic              full;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WCNT_W-1:0] word_cnt;

    logic shift_load;
    logic last_shift;
    logic word_done;
    logic take;

    assign shift_load = (state == LOAD) && full;
    assign last_shift = shift_load && (bit_cnt == LAST_BIT);
    assign word_done  = shift_load && (bit_idx == LAST_IDX);
    // Refill is allowed while the last bit of the current word is leaving, so words stream without a bubble.
    assign s_ready    = (state == LOAD) && (word_cnt != WORDS) && (!full || (bit_idx == LAST_IDX));
    assign take       = s_valid && s_ready;

`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
    logic [7:0] load_crc;
    logic [7:0] tail_crc;
    logic       error_q;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign error = error_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign error       = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state    <= IDLE;
            word_q   <= '0;
            bit_idx  <= '0;
            full     <= 1'b0;
            bit_cnt  <= '0;
            word_cnt <= '0;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
            load_crc <= 8'h00;
            tail_crc <= 8'h00;
            error_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        full     <= 1'b0;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
                        load_crc <= 8'h00;
                        tail_crc <= 8'h00;
                        error_q  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (shift_load) begin
                        bit_cnt <= bit_cnt + 1'b1;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
                        load_crc <= crc8_step(load_crc, word_q[0]);
`endif
                    end
                    if (take) begin
                        word_q   <= s_data;
                        bit_idx  <= '0;
                        full     <= 1'b1;
                        word_cnt <= word_cnt + 1'b1;
                    end else if (shift_load) begin
                        word_q  <= word_q >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (word_done) begin
                            full <= 1'b0;
                        end
                    end
                    // Upper bits of a partial final word are simply dropped here.
                    if (last_shift) begin
                        full    <= 1'b0;
                        bit_cnt <= '0;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
                        state   <= VERIFY;
`else
                        state   <= DONE;
`endif
                    end
                end
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
                VERIFY: begin
                    bit_cnt  <= bit_cnt + 1'b1;
                    tail_crc <= crc8_step(tail_crc, ccff_tail);
                    if (bit_cnt == LAST_BIT) begin
                        error_q <= (crc8_step(tail_crc, ccff_tail) != load_crc);
                        state   <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        case (state)
            LOAD: begin
                ccff_shift_en = full;
                ccff_head     = full & word_q[0];
            end
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
            // Tail feeds straight back to head so the ring is exactly CHAIN_LEN long.
            VERIFY: begin
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
            end
`endif
            default: begin
                ccff_shift_en = 1'b0;
                ccff_head     = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: 20-flop chain model, words A5/3C/F9.
module tb_ccff_bitstream_loader;

    localparam int CL = 20;
    localparam int WW = 8;
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
    localparam int VX = CL;
`else
    localparam int VX = 0;
`endif
    // Bits A5, 3C, 9 LSB-first, first loaded bit ending at the tail (chain[19]).
    localparam logic [CL-1:0] EXP_CHAIN = 20'hA53C9;

    logic          prog_clk = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          ccff_shift_en;
    logic          busy;
    logic          done;
    logic          error;

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 prog_clk = ~prog_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    // Fabric chain model: shifts on prog_clk when enabled; flip_now corrupts flop 10.
    logic [CL-1:0] chain = '0;
    logic          flip_now = 1'b0;
    logic          tail_tog = 1'b0;
    logic          tog_en = 1'b0;
    always @(posedge prog_clk)
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head} ^ (flip_now ? 20'h00400 : 20'h0);
    assign ccff_tail = chain[CL-1] ^ tail_tog;
    always @(negedge prog_clk) if (tog_en) tail_tog <= ~tail_tog;

    int   shift_tot = 0;
    int   rise_tot = 0;
    int   done_tot = 0;
    logic prev_en = 1'b0;
    always @(negedge prog_clk) begin
        if (ccff_shift_en) shift_tot <= shift_tot + 1;
        if (ccff_shift_en && !prev_en) rise_tot <= rise_tot + 1;
        if (done) done_tot <= done_tot + 1;
        prev_en <= ccff_shift_en;
    end

    task automatic run_op(input bit stall2, input bit pulse_start, input int flip_at,
                          output int lat, output int dshift, output int drises,
                          output int ddones, output logic err_at_done);
        logic [WW-1:0] words [3];
        int s0, r0, d0, sc, g;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF9;
        @(negedge prog_clk);
        s0 = shift_tot; r0 = rise_tot; d0 = done_tot;
        start = 1'b1; sc = cyc;
        @(negedge prog_clk);
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            if (w == 1 && stall2) begin
                s_valid = 1'b0;
                g = 0;
                while (!s_ready && g < 100) begin @(negedge prog_clk); g++; end
                repeat (3) @(negedge prog_clk);
            end
            s_valid = 1'b1; s_data = words[w];
            g = 0;
            while (!s_ready && g < 100) begin @(negedge prog_clk); g++; end
            if (g >= 100) begin
                checks++; errors++;
                $display("FAIL handshake_timeout word %0d: s_ready never rose within 100 cycles", w);
            end
            @(negedge prog_clk);
        end
        s_valid = 1'b0; s_data = 8'($urandom);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL s_ready_after_last: got %b expected 0", s_ready);
        end
        if (pulse_start) begin
            start = 1'b1; @(negedge prog_clk); start = 1'b0;
        end
        g = 0;
        while (!done && g < 200) begin
            flip_now = (flip_at != 0 && cyc - sc == flip_at);
            @(negedge prog_clk); g++;
        end
        flip_now = 1'b0;
        if (g >= 200) begin
            checks++; errors++;
            $display("FAIL done_timeout: done not seen within 200 cycles");
        end
        lat = cyc - sc;
        err_at_done = error;
        @(negedge prog_clk);
        dshift = shift_tot - s0; drises = rise_tot - r0; ddones = done_tot - d0;
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        checks++;
        if ({s_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {s_ready, ccff_head, ccff_shift_en, busy, done, error});
        end
        prog_reset_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        checks++;
        if ({s_ready, ccff_shift_en, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b expected 00000",
                     {s_ready, ccff_shift_en, busy, done, error});
        end
    endtask

    task automatic test_basic();
        int lat, ds, dr, dd; logic e;
        run_op(1'b0, 1'b0, 0, lat, ds, dr, dd, e);
        checks++; if (lat !== CL + 2 + VX) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, CL + 2 + VX); end
        checks++; if (ds !== CL + VX) begin errors++; $display("FAIL basic_shifts: got %0d expected %0d", ds, CL + VX); end
        checks++; if (dr !== 1) begin errors++; $display("FAIL basic_contiguous: got %0d bursts expected 1", dr); end
        checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL basic_chain: got %h expected %h", chain, EXP_CHAIN); end
        checks++; if (dd !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", dd); end
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL basic_after_done: got done,busy=%b expected 00", {done, busy}); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_error: got %b expected 0", e); end
    endtask

    task automatic test_stall();
        int lat, ds, dr, dd; logic e;
        run_op(1'b1, 1'b0, 0, lat, ds, dr, dd, e);
        checks++; if (lat !== CL + 5 + VX) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, CL + 5 + VX); end
        checks++; if (ds !== CL + VX) begin errors++; $display("FAIL stall_shifts: got %0d expected %0d", ds, CL + VX); end
        checks++; if (dr !== 2) begin errors++; $display("FAIL stall_bursts: got %0d expected 2", dr); end
        checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL stall_chain: got %h expected %h", chain, EXP_CHAIN); end
    endtask

    task automatic test_start_ignored();
        int lat, ds, dr, dd; logic e;
        chain = '0;
        run_op(1'b0, 1'b1, 0, lat, ds, dr, dd, e);
        checks++; if (ds !== CL + VX) begin errors++; $display("FAIL restart_shifts: got %0d expected %0d", ds, CL + VX); end
        checks++; if (lat !== CL + 2 + VX) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", lat, CL + 2 + VX); end
        checks++; if (dd !== 1) begin errors++; $display("FAIL restart_done_pulses: got %0d expected 1", dd); end
    endtask

    task automatic test_reset_mid();
        int n, g, d0;
        @(negedge prog_clk);
        d0 = done_tot;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
        g = 0;
        while (!s_ready && g < 20) begin @(negedge prog_clk); g++; end
        @(negedge prog_clk);
        s_valid = 1'b0;
        n = 0; g = 0;
        while (n < 7 && g < 50) begin
            if (ccff_shift_en) n++;
            if (n < 7) begin @(negedge prog_clk); g++; end
        end
        checks++; if (n !== 7) begin errors++; $display("FAIL midreset_shift_count: got %0d expected 7", n); end
        prog_reset_n = 1'b0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        checks++; if ({busy, ccff_shift_en, s_ready} !== 3'b000) begin
            errors++; $display("FAIL midreset_outputs: got busy,shift_en,s_ready=%b expected 000", {busy, ccff_shift_en, s_ready});
        end
        repeat (30) @(negedge prog_clk);
        checks++; if (done_tot - d0 !== 0) begin errors++; $display("FAIL midreset_done: got %0d pulses expected 0", done_tot - d0); end
        checks++; if ({busy, error} !== 2'b00) begin errors++; $display("FAIL midreset_idle: got busy,error=%b expected 00", {busy, error}); end
    endtask

`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
    task automatic test_verify_fault();
        int lat, ds, dr, dd; logic e;
        run_op(1'b0, 1'b0, CL + 5, lat, ds, dr, dd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL fault_error_at_done: got %b expected 1", e); end
        repeat (3) @(negedge prog_clk);
        checks++; if ({busy, error} !== 2'b01) begin errors++; $display("FAIL fault_error_sticky: got busy,error=%b expected 01", {busy, error}); end
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        checks++; if ({busy, error} !== 2'b10) begin errors++; $display("FAIL fault_error_clear: got busy,error=%b expected 10", {busy, error}); end
        prog_reset_n = 1'b0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
    endtask
`else
    task automatic test_tail_ignored();
        int lat, ds, dr, dd; logic e;
        tog_en = 1'b1;
        run_op(1'b0, 1'b0, 0, lat, ds, dr, dd, e);
        tog_en = 1'b0;
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL tail_error: got %b expected 0", e); end
        checks++; if (lat !== CL + 2) begin errors++; $display("FAIL tail_latency: got %0d expected %0d", lat, CL + 2); end
        checks++; if (ds !== CL) begin errors++; $display("FAIL tail_shifts: got %0d expected %0d", ds, CL); end
        checks++; if (chain !== EXP_CHAIN) begin errors++; $display("FAIL tail_chain: got %h expected %h", chain, EXP_CHAIN); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid();
`ifdef CCFF_BITSTREAM_LOADER_VERIFY_EN
        test_verify_fault();
`else
        test_tail_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
